// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the screen-coordinate type.
// Overlay stages import this package for their screen bounds.
package vga_timing_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned COUNT_W = 10;

    typedef logic [COUNT_W-1:0] count_t;

    // Half-open window test: lo <= c < hi.
    function automatic logic in_window(input count_t c, input int unsigned lo,
                                       input int unsigned hi);
        return (32'(c) >= lo) && (32'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo position counter for one screen axis, with a wrap strobe and a
// sync-window decode of the value the counter is about to take.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL,
    parameter int unsigned SYNC_START = H_SYNC_START,
    parameter int unsigned SYNC_END   = H_SYNC_END
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   en_i,
    output count_t count_o,
    output count_t count_next_o,
    output logic   wrap_o,
    output logic   sync_next_o
);

    localparam count_t Last = count_t'(TOTAL - 1);

    count_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        wrap_o  = en_i && (count_q == Last);
        if (en_i) begin
            count_d = wrap_o ? '0 : count_q + count_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Decoding the next value lets the caller register sync on the same edge
    // the count changes, so both move together.
    assign sync_next_o  = in_window(count_d, SYNC_START, SYNC_END);
    assign count_next_o = count_d;
    assign count_o      = count_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate divider, H/V position counters, registered
// active-low syncs and visible-area flag, plus the end-of-frame strobe.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_end
);

    import vga_timing_pkg::*;

    localparam int unsigned HTotal     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HSyncStart = H_DISPLAY + H_FRONT;
    localparam int unsigned VSyncStart = V_DISPLAY + V_FRONT;

    // A one-bit divider that never leaves 0 keeps pixel_tick high for CLK_DIV = 1.
    localparam int unsigned   DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;

    count_t h_count, h_next, v_count, v_next;
    logic   h_wrap, v_wrap, h_sync_next, v_sync_next;
    logic   hsync_q, vsync_q, video_on_q;
    logic   hsync_d, vsync_d, video_on_d;

    assign pixel_tick = (div_q == DivLast);

    always_comb begin
        div_d = div_q + DivW'(1);
        if (pixel_tick) begin
            div_d = '0;
        end
    end

    vga_axis_counter #(
        .TOTAL      (HTotal),
        .SYNC_START (HSyncStart),
        .SYNC_END   (HSyncStart + H_SYNC)
    ) u_h_counter (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (pixel_tick),
        .count_o      (h_count),
        .count_next_o (h_next),
        .wrap_o       (h_wrap),
        .sync_next_o  (h_sync_next)
    );

    vga_axis_counter #(
        .TOTAL      (VTotal),
        .SYNC_START (VSyncStart),
        .SYNC_END   (VSyncStart + V_SYNC)
    ) u_v_counter (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (h_wrap),
        .count_o      (v_count),
        .count_next_o (v_next),
        .wrap_o       (v_wrap),
        .sync_next_o  (v_sync_next)
    );

    always_comb begin
        hsync_d    = ~h_sync_next;
        vsync_d    = ~v_sync_next;
        video_on_d = (h_next < count_t'(H_DISPLAY)) && (v_next < count_t'(V_DISPLAY));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q      <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    // The V wrap already requires pixel_tick and the H wrap, so it is exactly
    // the last-pixel-of-frame condition.
    assign frame_end = v_wrap;
    assign HCount    = h_count;
    assign VCount    = v_count;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: full-size, small-raster and CLK_DIV=1 builds
// run side by side; directed expectations are matched by clock count.
module tb_vga_sync_gen;

    logic clk;
    logic rst_n;
    int   cyc;
    int   phase;
    int   n_vec;
    int   n_err;

    logic [9:0] m_h, m_v, s_h, s_v, f_h, f_v;
    logic m_hs, m_vs, m_von, m_pt, m_fe;
    logic s_hs, s_vs, s_von, s_pt, s_fe;
    logic f_hs, f_vs, f_von, f_pt, f_fe;

    // Full 640x480 timing, two clocks per pixel.
    vga_sync_gen u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .HCount     (m_h),
        .VCount     (m_v),
        .hsync      (m_hs),
        .vsync      (m_vs),
        .video_on   (m_von),
        .pixel_tick (m_pt),
        .frame_end  (m_fe)
    );

    // 24x10 raster: visible 16x6, hsync 18..21, vsync 7..8; frame = 480 clks.
    vga_sync_gen #(
        .CLK_DIV   (2),
        .H_DISPLAY (16),
        .H_FRONT   (2),
        .H_SYNC    (4),
        .H_BACK    (2),
        .V_DISPLAY (6),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .HCount     (s_h),
        .VCount     (s_v),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .video_on   (s_von),
        .pixel_tick (s_pt),
        .frame_end  (s_fe)
    );

    vga_sync_gen #(
        .CLK_DIV (1)
    ) u_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .HCount     (f_h),
        .VCount     (f_v),
        .hsync      (f_hs),
        .vsync      (f_vs),
        .video_on   (f_von),
        .pixel_tick (f_pt),
        .frame_end  (f_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks since the last reset release; value N is what the DUTs hold after edge N.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    typedef struct {
        int         at;
        int         dut;
        string      name;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       fe;
    } exp_t;

    exp_t sb_q[$];

    task automatic expect_at(input int at, input int dut, input string name, input int h,
                             input int v, input bit hs, input bit vs, input bit von,
                             input bit pt, input bit fe);
        exp_t e;
        e.at = at;   e.dut = dut; e.name = name;
        e.h = 10'(h); e.v = 10'(v);
        e.hs = hs;   e.vs = vs;   e.von = von; e.pt = pt; e.fe = fe;
        sb_q.push_back(e);
    endtask

    task automatic run_to(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 100000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    // Monitor: aggregate window counters plus scoreboard matching.
    int s_vs_low, s_fe_cnt, s_rect, f_pt_cnt, f_hs_low, m_pt_cnt;

    task automatic check_cnt(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        s_vs_low = 0; s_fe_cnt = 0; s_rect = 0; f_pt_cnt = 0; f_hs_low = 0; m_pt_cnt = 0;
    end

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [24:0] act, req;
        if (phase == 0 && cyc >= 480 && cyc <= 959) begin
            if (!s_vs) s_vs_low++;
            if (s_fe) s_fe_cnt++;
            if (s_pt && s_von && s_h >= 2 && s_h <= 9 && s_v >= 1 && s_v <= 3) s_rect++;
            if (f_pt) f_pt_cnt++;
            if (!f_hs) f_hs_low++;
            if (m_pt) m_pt_cnt++;
        end
        if (phase == 0 && cyc == 960) begin
            check_cnt("small_vsync_low_clks", s_vs_low, 96);
            check_cnt("small_frame_end_pulses", s_fe_cnt, 1);
            check_cnt("small_rect_pixels", s_rect, 24);
            check_cnt("fast_pixel_tick_clks", f_pt_cnt, 480);
            check_cnt("fast_hsync_low_clks", f_hs_low, 96);
            check_cnt("main_pixel_ticks", m_pt_cnt, 240);
        end
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at <= cyc) begin
                e = sb_q[i];
                sb_q.delete(i);
                case (e.dut)
                    0:       act = {m_h, m_v, m_hs, m_vs, m_von, m_pt, m_fe};
                    1:       act = {s_h, s_v, s_hs, s_vs, s_von, s_pt, s_fe};
                    default: act = {f_h, f_v, f_hs, f_vs, f_von, f_pt, f_fe};
                endcase
                req = {e.h, e.v, e.hs, e.vs, e.von, e.pt, e.fe};
                n_vec++;
                if (act !== req || e.at != cyc) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d (due %0d): got H=%0d V=%0d hs=%b vs=%b von=%b pt=%b fe=%b, want H=%0d V=%0d hs=%b vs=%b von=%b pt=%b fe=%b",
                             e.name, cyc, e.at, act[24:15], act[14:5], act[4], act[3],
                             act[2], act[1], act[0], e.h, e.v, e.hs, e.vs, e.von, e.pt,
                             e.fe);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        phase = 0;
        repeat (2) @(posedge clk);
        #1;
        //         at  dut name            H    V   hs vs von pt fe
        expect_at(0,    0, "main_rst",      0,   0,  1, 1, 0, 0, 0);
        expect_at(0,    1, "small_rst",     0,   0,  1, 1, 0, 0, 0);
        expect_at(0,    2, "fast_rst",      0,   0,  1, 1, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        expect_at(1,    0, "main_release",  0,   0,  1, 1, 1, 1, 0);
        expect_at(2,    0, "main_step",     1,   0,  1, 1, 1, 0, 0);
        expect_at(1279, 0, "main_h639",     639, 0,  1, 1, 1, 1, 0);
        expect_at(1280, 0, "main_h640",     640, 0,  1, 1, 0, 0, 0);
        expect_at(1311, 0, "main_h655",     655, 0,  1, 1, 0, 1, 0);
        expect_at(1312, 0, "main_hs_fall",  656, 0,  0, 1, 0, 0, 0);
        expect_at(1503, 0, "main_h751",     751, 0,  0, 1, 0, 1, 0);
        expect_at(1504, 0, "main_hs_rise",  752, 0,  1, 1, 0, 0, 0);
        expect_at(1599, 0, "main_h799",     799, 0,  1, 1, 0, 1, 0);
        expect_at(1600, 0, "main_line1",    0,   1,  1, 1, 1, 0, 0);
        expect_at(1601, 0, "main_line1_tk", 0,   1,  1, 1, 1, 1, 0);
        expect_at(1864, 0, "main_pre_rst",  132, 1,  1, 1, 1, 0, 0);
        expect_at(1,    1, "small_release", 0,   0,  1, 1, 1, 1, 0);
        expect_at(36,   1, "small_hs_low",  18,  0,  0, 1, 0, 0, 0);
        expect_at(335,  1, "small_v6_end",  23,  6,  1, 1, 0, 1, 0);
        expect_at(336,  1, "small_vs_fall", 0,   7,  1, 0, 0, 0, 0);
        expect_at(431,  1, "small_v8_end",  23,  8,  1, 0, 0, 1, 0);
        expect_at(432,  1, "small_vs_rise", 0,   9,  1, 1, 0, 0, 0);
        expect_at(478,  1, "small_last_nt", 23,  9,  1, 1, 0, 0, 0);
        expect_at(479,  1, "small_frm_end", 23,  9,  1, 1, 0, 1, 1);
        expect_at(480,  1, "small_dbl_wrap", 0,  0,  1, 1, 1, 0, 0);
        expect_at(1864, 1, "small_pre_rst", 20,  8,  0, 0, 0, 0, 0);
        expect_at(1,    2, "fast_release",  1,   0,  1, 1, 1, 1, 0);
        expect_at(639,  2, "fast_h639",     639, 0,  1, 1, 1, 1, 0);
        expect_at(640,  2, "fast_h640",     640, 0,  1, 1, 0, 1, 0);
        expect_at(655,  2, "fast_h655",     655, 0,  1, 1, 0, 1, 0);
        expect_at(656,  2, "fast_hs_fall",  656, 0,  0, 1, 0, 1, 0);
        expect_at(751,  2, "fast_h751",     751, 0,  0, 1, 0, 1, 0);
        expect_at(752,  2, "fast_hs_rise",  752, 0,  1, 1, 0, 1, 0);
        expect_at(799,  2, "fast_h799",     799, 0,  1, 1, 0, 1, 0);
        expect_at(800,  2, "fast_line1",    0,   1,  1, 1, 1, 1, 0);
        expect_at(1864, 2, "fast_pre_rst",  264, 2,  1, 1, 1, 1, 0);
        rst_n = 1'b1;

        // Mid-frame reset with both syncs of the small raster active.
        run_to(1864);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        phase = 1;
        expect_at(0,    0, "main_midrst",   0,   0,  1, 1, 0, 0, 0);
        expect_at(0,    1, "small_midrst",  0,   0,  1, 1, 0, 0, 0);
        expect_at(0,    2, "fast_midrst",   0,   0,  1, 1, 0, 1, 0);
        expect_at(1,    0, "main_restart",  0,   0,  1, 1, 1, 1, 0);
        expect_at(1,    1, "small_restart", 0,   0,  1, 1, 1, 1, 0);
        expect_at(2,    1, "small_rs_step", 1,   0,  1, 1, 1, 0, 0);
        expect_at(48,   1, "small_rs_line", 0,   1,  1, 1, 1, 0, 0);
        expect_at(1,    2, "fast_restart",  1,   0,  1, 1, 1, 1, 0);
        rst_n = 1'b1;
        run_to(64);
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
